// File: rtl/wsched_stream_if.sv
// rtl/wsched_stream_if.sv - message-in / schedule-out stream bundle for wsched_stream
// The abort signal exists only when WSCHED_ABORT_EN is defined.
interface wsched_stream_if #(parameter int WORD_W = 32);
   logic              start;
   logic              m_valid;
   logic              m_ready;
   logic [WORD_W-1:0] m_data;
   logic              w_valid;
   logic              w_ready;
   logic [WORD_W-1:0] w_data;
   logic [6:0]        w_idx;
   logic              busy;
   logic              done;
`ifdef WSCHED_ABORT_EN
   logic              abort;
`endif

   modport master (
      output start, m_valid, m_data, w_ready,
`ifdef WSCHED_ABORT_EN
      output abort,
`endif
      input  m_ready, w_valid, w_data, w_idx, busy, done
   );

   modport slave (
      input  start, m_valid, m_data, w_ready,
`ifdef WSCHED_ABORT_EN
      input  abort,
`endif
      output m_ready, w_valid, w_data, w_idx, busy, done
   );
endinterface

// File: rtl/wsched_stream.sv
// rtl/wsched_stream.sv - SHA-2 message schedule generator, 16-word sliding window
// Optional abort input enabled by defining WSCHED_ABORT_EN.
module wsched_stream #(
   parameter int WORD_W = 32,
   parameter int ROUNDS = 64
) (
   input  logic            clk,
   input  logic            reset_n,
   wsched_stream_if.slave  bus
);
   localparam logic [6:0] T_LOAD_END = 7'd15;
   localparam logic [6:0] T_LAST     = 7'(ROUNDS - 1);

   typedef enum logic [1:0] {IDLE, LOAD, EXPAND} state_t;

   state_t            state, state_nxt;
   logic [6:0]        t;
   logic [WORD_W-1:0] win [16];
   logic [WORD_W-1:0] w_new;
   logic              xfer;
   logic              abort_req;
   logic              done_q;

   function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int n);
      return (x >> n) | (x << (WORD_W - n));
   endfunction

   function automatic logic [WORD_W-1:0] sig0(input logic [WORD_W-1:0] x);
      if (WORD_W == 64) return rotr(x, 1) ^ rotr(x, 8) ^ (x >> 7);
      else              return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [WORD_W-1:0] sig1(input logic [WORD_W-1:0] x);
      if (WORD_W == 64) return rotr(x, 19) ^ rotr(x, 61) ^ (x >> 6);
      else              return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

   // win[k] holds W[t-1-k], so these taps are W[t-2], W[t-7], W[t-15], W[t-16]
   assign w_new = sig1(win[1]) + win[6] + sig0(win[14]) + win[15];

`ifdef WSCHED_ABORT_EN
   assign abort_req = bus.abort;
`else
   assign abort_req = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      bus.m_ready = 1'b0;
      bus.w_valid = 1'b0;
      bus.w_data  = '0;
      xfer        = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) state_nxt = LOAD;
         end
         LOAD: begin
            bus.w_valid = bus.m_valid;
            bus.m_ready = bus.w_ready;
            bus.w_data  = bus.m_data;
         end
         EXPAND: begin
            bus.w_valid = 1'b1;
            bus.w_data  = w_new;
         end
         default: state_nxt = IDLE;
      endcase
      xfer = bus.w_valid & bus.w_ready;
      if (xfer && state == LOAD && t == T_LOAD_END) state_nxt = EXPAND;
      if (xfer && state == EXPAND && t == T_LAST)   state_nxt = IDLE;
      if (abort_req) state_nxt = IDLE;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         t      <= '0;
         done_q <= 1'b0;
         for (int k = 0; k < 16; k++) win[k] <= '0;
      end else if (abort_req) begin
         t      <= '0;
         done_q <= 1'b0;
         for (int k = 0; k < 16; k++) win[k] <= '0;
      end else begin
         done_q <= xfer && state == EXPAND && t == T_LAST;
         if (state == IDLE && bus.start) begin
            t <= '0;
         end else if (xfer) begin
            t <= (state == EXPAND && t == T_LAST) ? 7'd0 : t + 7'd1;
            win[0] <= bus.w_data;
            for (int k = 1; k < 16; k++) win[k] <= win[k-1];
         end
      end
   end

   assign bus.w_idx = t;
   assign bus.busy  = (state != IDLE);
   assign bus.done  = done_q;
endmodule

// File: tb/tb_wsched_stream.sv
// tb/tb_wsched_stream.sv - scoreboard bench for wsched_stream (32/64 and 64/80 instances)
// Define WSCHED_ABORT_EN to also exercise the abort path.
module tb_wsched_stream;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   wsched_stream_if #(.WORD_W(32)) bus32();
   wsched_stream_if #(.WORD_W(64)) bus64();

   wsched_stream #(.WORD_W(32), .ROUNDS(64)) dut32 (.clk(clk), .reset_n(reset_n), .bus(bus32.slave));
   wsched_stream #(.WORD_W(64), .ROUNDS(80)) dut64 (.clk(clk), .reset_n(reset_n), .bus(bus64.slave));

   int checks = 0;
   int errors = 0;
   logic [63:0] blk   [16];
   logic [63:0] exp_w [80];
   logic [63:0] obs   [80];
   logic [31:0] sb   [$];
   logic [63:0] sb64 [$];

   function automatic logic [63:0] m_rotr(input logic [63:0] x, input int n, input bit wide);
      logic [31:0] y;
      if (wide) return (x >> n) | (x << (64 - n));
      y = x[31:0];
      return {32'h0, (y >> n) | (y << (32 - n))};
   endfunction

   function automatic logic [63:0] m_sig0(input logic [63:0] x, input bit wide);
      if (wide) return m_rotr(x, 1, 1) ^ m_rotr(x, 8, 1) ^ (x >> 7);
      return m_rotr(x, 7, 0) ^ m_rotr(x, 18, 0) ^ {32'h0, x[31:0] >> 3};
   endfunction

   function automatic logic [63:0] m_sig1(input logic [63:0] x, input bit wide);
      if (wide) return m_rotr(x, 19, 1) ^ m_rotr(x, 61, 1) ^ (x >> 6);
      return m_rotr(x, 17, 0) ^ m_rotr(x, 19, 0) ^ {32'h0, x[31:0] >> 10};
   endfunction

   task automatic build_model(input bit wide, input int rounds);
      logic [63:0] s;
      for (int i = 0; i < 16; i++) exp_w[i] = wide ? blk[i] : {32'h0, blk[i][31:0]};
      for (int i = 16; i < rounds; i++) begin
         s = m_sig1(exp_w[i-2], wide) + exp_w[i-7] + m_sig0(exp_w[i-15], wide) + exp_w[i-16];
         exp_w[i] = wide ? s : {32'h0, s[31:0]};
      end
   endtask

   task automatic set_abc;
      for (int i = 0; i < 16; i++) blk[i] = 64'h0;
      blk[0]  = 64'h61626380;
      blk[15] = 64'h00000018;
   endtask

   task automatic set_random;
      for (int i = 0; i < 16; i++) blk[i] = {$urandom, $urandom};
   endtask

   task automatic do_start32;
      @(posedge clk); #1;
      bus32.start = 1'b1;
      @(posedge clk); #1;
      bus32.start = 1'b0;
   endtask

   // Assumes the DUT entered LOAD at the last edge; streams one block against the scoreboard.
   task automatic run_block(input int stall_pct, input int gap_pct, input int start_mid, input bit chain);
      int li = 0, n = 0, cyc = 0;
      bit prev_stall = 0, hold_m = 0;
      logic [31:0] prev_w = '0, expv;
      build_model(0, 64);
      sb.delete();
      for (int i = 0; i < 64; i++) sb.push_back(exp_w[i][31:0]);
      while (sb.size() != 0 && cyc < 3000) begin
         if (!hold_m)
            bus32.m_valid = (li < 16) ? ($urandom_range(0, 99) >= gap_pct) : 1'($urandom_range(0, 1));
         bus32.m_data  = (li < 16) ? blk[li][31:0] : $urandom;
         bus32.w_ready = ($urandom_range(0, 99) >= stall_pct);
         bus32.start   = (n == start_mid);
         @(negedge clk);
         checks++;
         if (bus32.m_ready && li >= 16) begin
            errors++; $display("FAIL m_ready_outside_load t=%0d got 1 exp 0", n);
         end
         if (prev_stall && bus32.w_valid && n >= 16) begin
            checks++;
            if (bus32.w_data !== prev_w) begin
               errors++; $display("FAIL stall_hold t=%0d got %h exp %h", n, bus32.w_data, prev_w);
            end
         end
         if (bus32.w_valid && bus32.w_ready) begin
            expv = sb.pop_front();
            checks++;
            if (bus32.w_data !== expv) begin
               errors++; $display("FAIL w_data t=%0d got %h exp %h", n, bus32.w_data, expv);
            end
            checks++;
            if (bus32.w_idx !== 7'(n)) begin
               errors++; $display("FAIL w_idx got %0d exp %0d", bus32.w_idx, n);
            end
            obs[n] = {32'h0, bus32.w_data};
            n++;
         end
         if (bus32.m_valid && bus32.m_ready) li++;
         prev_stall = bus32.w_valid && !bus32.w_ready;
         prev_w     = bus32.w_data;
         hold_m     = bus32.m_valid && !bus32.m_ready;
         @(posedge clk); #1;
         cyc++;
      end
      checks++;
      if (sb.size() != 0) begin
         errors++; $display("FAIL block_timeout got %0d words left exp 0", sb.size());
      end
      bus32.m_valid = 1'b0;
      bus32.w_ready = 1'b1;
      bus32.start   = chain;
      @(negedge clk);
      checks++;
      if (bus32.done !== 1'b1 || bus32.w_valid !== 1'b0) begin
         errors++; $display("FAIL done_pulse got done=%b w_valid=%b exp 1/0", bus32.done, bus32.w_valid);
      end
      if (stall_pct == 0 && gap_pct == 0) begin
         checks++;
         if (cyc != 64) begin
            errors++; $display("FAIL start_to_done got %0d exp 65 cycles", cyc + 1);
         end
      end
      @(posedge clk); #1;
      bus32.start = 1'b0;
      if (!chain) begin
         @(negedge clk);
         checks++;
         if (bus32.done !== 1'b0 || bus32.busy !== 1'b0) begin
            errors++; $display("FAIL done_single got done=%b busy=%b exp 0/0", bus32.done, bus32.busy);
         end
      end
   endtask

   task automatic test_reset;
      #12;
      checks++;
      if ({bus32.m_ready, bus32.w_valid, bus32.busy, bus32.done} !== 4'b0 ||
          bus32.w_data !== 32'h0 || bus32.w_idx !== 7'd0) begin
         errors++; $display("FAIL reset32 got m_ready=%b w_valid=%b busy=%b done=%b w_data=%h w_idx=%0d exp all 0",
                            bus32.m_ready, bus32.w_valid, bus32.busy, bus32.done, bus32.w_data, bus32.w_idx);
      end
      checks++;
      if ({bus64.m_ready, bus64.w_valid, bus64.busy, bus64.done} !== 4'b0 || bus64.w_data !== 64'h0) begin
         errors++; $display("FAIL reset64 got w_valid=%b busy=%b w_data=%h exp 0", bus64.w_valid, bus64.busy, bus64.w_data);
      end
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_abc;
      logic [31:0] ref_w [5];
      ref_w = '{32'h61626380, 32'h000F0000, 32'h7DA86405, 32'h600003C6, 32'h3E9D7B78};
      set_abc();
      do_start32();
      run_block(0, 0, -1, 0);
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (obs[16+i][31:0] !== ref_w[i]) begin
            errors++; $display("FAIL abc_W%0d got %h exp %h", 16 + i, obs[16+i][31:0], ref_w[i]);
         end
      end
   endtask

   task automatic test_stall;
      set_abc();
      do_start32();
      run_block(40, 30, -1, 0);
   endtask

   task automatic test_back_to_back;
      set_random();
      do_start32();
      run_block(0, 0, 30, 1);
      set_random();
      run_block(0, 0, -1, 0);
   endtask

   task automatic test_reset_mid;
      set_abc();
      do_start32();
      for (int i = 0; i < 40; i++) begin
         bus32.m_valid = (i < 16);
         bus32.m_data  = (i < 16) ? blk[i][31:0] : 32'h0;
         bus32.w_ready = 1'b1;
         @(posedge clk); #1;
      end
      bus32.m_valid = 1'b0;
      checks++;
      if (bus32.w_idx !== 7'd40 || bus32.busy !== 1'b1) begin
         errors++; $display("FAIL pre_reset got w_idx=%0d busy=%b exp 40/1", bus32.w_idx, bus32.busy);
      end
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if ({bus32.m_ready, bus32.w_valid, bus32.busy, bus32.done} !== 4'b0 ||
          bus32.w_data !== 32'h0 || bus32.w_idx !== 7'd0) begin
         errors++; $display("FAIL async_reset got w_valid=%b busy=%b w_data=%h w_idx=%0d exp all 0",
                            bus32.w_valid, bus32.busy, bus32.w_data, bus32.w_idx);
      end
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      checks++;
      if (bus32.done !== 1'b0) begin
         errors++; $display("FAIL done_after_reset got 1 exp 0");
      end
      set_random();
      do_start32();
      run_block(0, 0, -1, 0);
   endtask

   task automatic test_wide;
      for (int b = 0; b < 2; b++) begin
         int li = 0, n = 0, done_cnt = 0;
         logic [63:0] expv;
         if (b == 0) for (int i = 0; i < 16; i++) blk[i] = 64'h0;
         else        set_random();
         build_model(1, 80);
         sb64.delete();
         for (int i = 0; i < 80; i++) sb64.push_back(exp_w[i]);
         @(posedge clk); #1;
         bus64.start = 1'b1;
         @(posedge clk); #1;
         bus64.start = 1'b0;
         for (int c = 0; c < 95; c++) begin
            bus64.m_valid = (li < 16);
            bus64.m_data  = (li < 16) ? blk[li] : 64'h0;
            bus64.w_ready = 1'b1;
            @(negedge clk);
            if (bus64.done) done_cnt++;
            if (bus64.w_valid && bus64.w_ready) begin
               expv = (sb64.size() != 0) ? sb64.pop_front() : 64'hx;
               checks++;
               if (bus64.w_data !== expv || bus64.w_idx !== 7'(n)) begin
                  errors++; $display("FAIL wide_word blk%0d t=%0d got %h idx %0d exp %h", b, n, bus64.w_data, bus64.w_idx, expv);
               end
               n++;
            end
            if (bus64.m_valid && bus64.m_ready) li++;
            @(posedge clk); #1;
         end
         bus64.m_valid = 1'b0;
         checks++;
         if (n != 80 || done_cnt != 1) begin
            errors++; $display("FAIL wide_count blk%0d got %0d words %0d dones exp 80/1", b, n, done_cnt);
         end
      end
   endtask

`ifdef WSCHED_ABORT_EN
   task automatic test_abort;
      int dones = 0;
      set_abc();
      do_start32();
      for (int i = 0; i < 20; i++) begin
         bus32.m_valid = (i < 16);
         bus32.m_data  = (i < 16) ? blk[i][31:0] : 32'h0;
         bus32.w_ready = 1'b1;
         @(posedge clk); #1;
      end
      bus32.m_valid = 1'b0;
      bus32.abort   = 1'b1;
      @(negedge clk);
      checks++;
      if (bus32.w_valid !== 1'b1 || bus32.w_idx !== 7'd20) begin
         errors++; $display("FAIL abort_pre got w_valid=%b w_idx=%0d exp 1/20", bus32.w_valid, bus32.w_idx);
      end
      @(posedge clk); #1;
      bus32.abort = 1'b0;
      @(negedge clk);
      checks++;
      if (bus32.busy !== 1'b0 || bus32.w_idx !== 7'd0 || bus32.w_valid !== 1'b0) begin
         errors++; $display("FAIL abort_idle got busy=%b w_idx=%0d w_valid=%b exp 0/0/0", bus32.busy, bus32.w_idx, bus32.w_valid);
      end
      for (int i = 0; i < 3; i++) begin
         if (bus32.done) dones++;
         @(negedge clk);
      end
      checks++;
      if (dones != 0) begin
         errors++; $display("FAIL abort_done got %0d pulses exp 0", dones);
      end
      set_random();
      do_start32();
      run_block(0, 0, -1, 0);
   endtask
`endif

   initial begin
      bus32.start = 1'b0; bus32.m_valid = 1'b0; bus32.m_data = '0; bus32.w_ready = 1'b0;
      bus64.start = 1'b0; bus64.m_valid = 1'b0; bus64.m_data = '0; bus64.w_ready = 1'b0;
`ifdef WSCHED_ABORT_EN
      bus32.abort = 1'b0;
      bus64.abort = 1'b0;
`endif
      test_reset();
      test_abc();
      test_stall();
      test_back_to_back();
      test_reset_mid();
      test_wide();
`ifdef WSCHED_ABORT_EN
      test_abort();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout got no finish exp finish");
      $fatal(1);
   end
endmodule
